// File: rtl/bali_pkg.sv
// Shared Bali core definitions: ALU operation codes and JVM opcode constants.
package bali_pkg;

  localparam int unsigned OPCODE_W = 8;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned ARGC_W   = 2;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_MUL  = 4'b0010,
    ALU_DIV  = 4'b0011,
    ALU_REM  = 4'b0100,
    ALU_NEG  = 4'b0101,
    ALU_OR   = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_INC  = 4'b1010,
    ALU_SHL  = 4'b1100,
    ALU_SHR  = 4'b1101,
    ALU_USHR = 4'b1110,
    ALU_AND  = 4'b1111
  } aluop_t;

  // ALU opcodes
  localparam logic [OPCODE_W-1:0] OP_IADD  = 8'h60;
  localparam logic [OPCODE_W-1:0] OP_ISUB  = 8'h64;
  localparam logic [OPCODE_W-1:0] OP_IMUL  = 8'h68;
  localparam logic [OPCODE_W-1:0] OP_IDIV  = 8'h6C;
  localparam logic [OPCODE_W-1:0] OP_IREM  = 8'h70;
  localparam logic [OPCODE_W-1:0] OP_INEG  = 8'h74;
  localparam logic [OPCODE_W-1:0] OP_ISHL  = 8'h78;
  localparam logic [OPCODE_W-1:0] OP_ISHR  = 8'h7A;
  localparam logic [OPCODE_W-1:0] OP_IUSHR = 8'h7C;
  localparam logic [OPCODE_W-1:0] OP_IAND  = 8'h7E;
  localparam logic [OPCODE_W-1:0] OP_IOR   = 8'h80;
  localparam logic [OPCODE_W-1:0] OP_IXOR  = 8'h82;
  localparam logic [OPCODE_W-1:0] OP_IINC  = 8'h84;

  // Opcodes carrying inline operand bytes
  localparam logic [OPCODE_W-1:0] OP_BIPUSH          = 8'h10;
  localparam logic [OPCODE_W-1:0] OP_SIPUSH          = 8'h11;
  localparam logic [OPCODE_W-1:0] OP_LDC             = 8'h12;
  localparam logic [OPCODE_W-1:0] OP_LDC_W           = 8'h13;
  localparam logic [OPCODE_W-1:0] OP_LDC2_W          = 8'h14;
  localparam logic [OPCODE_W-1:0] OP_ILOAD           = 8'h15;
  localparam logic [OPCODE_W-1:0] OP_ALOAD           = 8'h19;
  localparam logic [OPCODE_W-1:0] OP_ISTORE          = 8'h36;
  localparam logic [OPCODE_W-1:0] OP_ASTORE          = 8'h3A;
  localparam logic [OPCODE_W-1:0] OP_IFEQ            = 8'h99;
  localparam logic [OPCODE_W-1:0] OP_JSR             = 8'hA8;
  localparam logic [OPCODE_W-1:0] OP_RET             = 8'hA9;
  localparam logic [OPCODE_W-1:0] OP_GETSTATIC       = 8'hB2;
  localparam logic [OPCODE_W-1:0] OP_INVOKESTATIC    = 8'hB8;
  localparam logic [OPCODE_W-1:0] OP_INVOKEINTERFACE = 8'hB9;
  localparam logic [OPCODE_W-1:0] OP_INVOKEDYNAMIC   = 8'hBA;
  localparam logic [OPCODE_W-1:0] OP_NEW             = 8'hBB;
  localparam logic [OPCODE_W-1:0] OP_NEWARRAY        = 8'hBC;
  localparam logic [OPCODE_W-1:0] OP_ANEWARRAY       = 8'hBD;
  localparam logic [OPCODE_W-1:0] OP_CHECKCAST       = 8'hC0;
  localparam logic [OPCODE_W-1:0] OP_INSTANCEOF      = 8'hC1;
  localparam logic [OPCODE_W-1:0] OP_WIDE            = 8'hC4;
  localparam logic [OPCODE_W-1:0] OP_MULTIANEWARRAY  = 8'hC5;
  localparam logic [OPCODE_W-1:0] OP_IFNULL          = 8'hC6;
  localparam logic [OPCODE_W-1:0] OP_IFNONNULL       = 8'hC7;
  localparam logic [OPCODE_W-1:0] OP_GOTO_W          = 8'hC8;
  localparam logic [OPCODE_W-1:0] OP_JSR_W           = 8'hC9;

endpackage

// File: rtl/opcode_decoder_if.sv
// Decode bus between fetch (master) and the opcode decoder (slave).
interface opcode_decoder_if;
  import bali_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                dec_en;
  logic [ALUOP_W-1:0]  aluop;
  logic [ARGC_W-1:0]   argc;
  logic                is_alu;
  logic [ALUOP_W-1:0]  aluop_q;
  logic [ARGC_W-1:0]   argc_q;
  logic                is_alu_q;

  modport master (
    output opcode, dec_en,
    input  aluop, argc, is_alu, aluop_q, argc_q, is_alu_q
  );

  modport slave (
    input  opcode, dec_en,
    output aluop, argc, is_alu, aluop_q, argc_q, is_alu_q
  );
endinterface

// File: rtl/opcode_decoder_comb.sv
// Pure combinational opcode decode: ALU operation, ALU flag and operand-byte count.
module opcode_decoder_comb
  import bali_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output aluop_t              aluop,
  output logic                is_alu,
  output logic [ARGC_W-1:0]   argc
);

  always_comb begin
    aluop  = ALU_ADD;
    is_alu = 1'b0;
    case (opcode)
      OP_IADD:  begin aluop = ALU_ADD;  is_alu = 1'b1; end
      OP_ISUB:  begin aluop = ALU_SUB;  is_alu = 1'b1; end
      OP_IMUL:  begin aluop = ALU_MUL;  is_alu = 1'b1; end
      OP_IDIV:  begin aluop = ALU_DIV;  is_alu = 1'b1; end
      OP_IREM:  begin aluop = ALU_REM;  is_alu = 1'b1; end
      OP_INEG:  begin aluop = ALU_NEG;  is_alu = 1'b1; end
      OP_ISHL:  begin aluop = ALU_SHL;  is_alu = 1'b1; end
      OP_ISHR:  begin aluop = ALU_SHR;  is_alu = 1'b1; end
      OP_IUSHR: begin aluop = ALU_USHR; is_alu = 1'b1; end
      OP_IAND:  begin aluop = ALU_AND;  is_alu = 1'b1; end
      OP_IOR:   begin aluop = ALU_OR;   is_alu = 1'b1; end
      OP_IXOR:  begin aluop = ALU_XOR;  is_alu = 1'b1; end
      OP_IINC:  begin aluop = ALU_INC;  is_alu = 1'b1; end
      default:  begin aluop = ALU_ADD;  is_alu = 1'b0; end
    endcase
  end

  // Count of 3 means "3 or more"; switch tables are sized by the fetch unit.
  always_comb begin
    argc = 2'd0;
    case (opcode) inside
      OP_BIPUSH, OP_LDC, [OP_ILOAD:OP_ALOAD], [OP_ISTORE:OP_ASTORE],
      OP_RET, OP_NEWARRAY:
        argc = 2'd1;
      OP_SIPUSH, OP_LDC_W, OP_LDC2_W, OP_IINC, [OP_IFEQ:OP_JSR],
      [OP_GETSTATIC:OP_INVOKESTATIC], OP_NEW, OP_ANEWARRAY,
      OP_CHECKCAST, OP_INSTANCEOF, OP_IFNULL, OP_IFNONNULL:
        argc = 2'd2;
      OP_INVOKEINTERFACE, OP_INVOKEDYNAMIC, OP_WIDE, OP_MULTIANEWARRAY,
      OP_GOTO_W, OP_JSR_W:
        argc = 2'd3;
      default:
        argc = 2'd0;
    endcase
  end

endmodule

// File: rtl/opcode_decoder.sv
// Bytecode decoder top: combinational decode plus a dec_en-gated pipeline register.
module opcode_decoder
  import bali_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  opcode_decoder_if.slave   bus
);

  aluop_t              aluop_c;
  logic                is_alu_c;
  logic [ARGC_W-1:0]   argc_c;

  opcode_decoder_comb u_comb (
    .opcode (bus.opcode),
    .aluop  (aluop_c),
    .is_alu (is_alu_c),
    .argc   (argc_c)
  );

  assign bus.aluop  = ALUOP_W'(aluop_c);
  assign bus.argc   = argc_c;
  assign bus.is_alu = is_alu_c;

  // Pipeline copy for the stage after decode; holds while dec_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.aluop_q  <= '0;
      bus.argc_q   <= '0;
      bus.is_alu_q <= 1'b0;
    end else if (bus.dec_en) begin
      bus.aluop_q  <= ALUOP_W'(aluop_c);
      bus.argc_q   <= argc_c;
      bus.is_alu_q <= is_alu_c;
    end
  end

endmodule

// File: tb/tb_opcode_decoder.sv
// Directed self-checking bench for opcode_decoder: combinational decode, register path, async reset.
module tb_opcode_decoder;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  opcode_decoder_if bus ();

  opcode_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] alu_ops   [13] = '{8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h74, 8'h78,
                                 8'h7A, 8'h7C, 8'h7E, 8'h80, 8'h82, 8'h84};
  logic [3:0] alu_codes [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000, 4'b1001,
                                 4'b1010};

  function automatic void ref_model(input logic [7:0] op, output logic [3:0] a,
                                    output logic [1:0] c, output logic i);
    a = 4'b0000;
    i = 1'b0;
    for (int j = 0; j < 13; j++) begin
      if (op == alu_ops[j]) begin
        a = alu_codes[j];
        i = 1'b1;
      end
    end
    c = 2'd0;
    if (op == 8'h10 || op == 8'h12 || (op >= 8'h15 && op <= 8'h19) ||
        (op >= 8'h36 && op <= 8'h3A) || op == 8'hA9 || op == 8'hBC)
      c = 2'd1;
    if (op == 8'h11 || op == 8'h13 || op == 8'h14 || op == 8'h84 ||
        (op >= 8'h99 && op <= 8'hA8) || (op >= 8'hB2 && op <= 8'hB8) ||
        op == 8'hBB || op == 8'hBD || op == 8'hC0 || op == 8'hC1 ||
        op == 8'hC6 || op == 8'hC7)
      c = 2'd2;
    if (op == 8'hB9 || op == 8'hBA || op == 8'hC4 || op == 8'hC5 ||
        op == 8'hC8 || op == 8'hC9)
      c = 2'd3;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dec_en = 1'b1;
    bus.opcode = 8'h7C;
    #1;
    total_cnt++;
    if (bus.aluop_q !== 4'h0) $display("FAIL reset_aluop_q got %h want %h", bus.aluop_q, 4'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus.argc_q !== 2'd0) $display("FAIL reset_argc_q got %0d want %0d", bus.argc_q, 0);
    else pass_cnt++;
    total_cnt++;
    if (bus.is_alu_q !== 1'b0) $display("FAIL reset_is_alu_q got %b want %b", bus.is_alu_q, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (bus.aluop !== 4'hE || bus.is_alu !== 1'b1)
      $display("FAIL reset_comb_tracks got %h/%b want %h/%b", bus.aluop, bus.is_alu, 4'hE, 1'b1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.aluop_q !== 4'h0) $display("FAIL reset_held_edge got %h want %h", bus.aluop_q, 4'h0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.dec_en = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.aluop_q !== 4'h0) $display("FAIL release_no_en got %h want %h", bus.aluop_q, 4'h0);
    else pass_cnt++;
    @(negedge clk);
    bus.dec_en = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.aluop_q !== 4'hE || bus.is_alu_q !== 1'b1 || bus.argc_q !== 2'd0)
      $display("FAIL release_first_capture got %h/%0d/%b want %h/%0d/%b",
               bus.aluop_q, bus.argc_q, bus.is_alu_q, 4'hE, 0, 1'b1);
    else pass_cnt++;
    @(negedge clk);
    bus.dec_en = 1'b0;
  endtask

  task automatic test_alu_sweep();
    for (int j = 0; j < 13; j++) begin
      bus.opcode = alu_ops[j];
      #1;
      total_cnt++;
      if (bus.aluop !== alu_codes[j] || bus.is_alu !== 1'b1)
        $display("FAIL alu_sweep op=%h got %b/%b want %b/%b",
                 alu_ops[j], bus.aluop, bus.is_alu, alu_codes[j], 1'b1);
      else pass_cnt++;
      #9;
    end
  endtask

  task automatic test_unlisted();
    logic [7:0] ops [3] = '{8'h00, 8'h02, 8'hFF};
    for (int j = 0; j < 3; j++) begin
      bus.opcode = ops[j];
      #1;
      total_cnt++;
      if (bus.aluop !== 4'h0 || bus.argc !== 2'd0 || bus.is_alu !== 1'b0)
        $display("FAIL unlisted op=%h got %h/%0d/%b want 0/0/0",
                 ops[j], bus.aluop, bus.argc, bus.is_alu);
      else pass_cnt++;
      #9;
    end
  endtask

  task automatic test_argc();
    logic [7:0] ops  [7] = '{8'h10, 8'h11, 8'h84, 8'hA7, 8'hC5, 8'hAA, 8'h60};
    logic [1:0] want [7] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
    for (int j = 0; j < 7; j++) begin
      bus.opcode = ops[j];
      #1;
      total_cnt++;
      if (bus.argc !== want[j])
        $display("FAIL argc op=%h got %0d want %0d", ops[j], bus.argc, want[j]);
      else pass_cnt++;
      #9;
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    bus.opcode = 8'h68;
    bus.dec_en = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.aluop_q !== 4'b0010 || bus.argc_q !== 2'd0 || bus.is_alu_q !== 1'b1)
      $display("FAIL reg_capture got %b/%0d/%b want 0010/0/1", bus.aluop_q, bus.argc_q, bus.is_alu_q);
    else pass_cnt++;
    @(negedge clk);
    bus.opcode = 8'h11;
    bus.dec_en = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.aluop_q !== 4'b0010 || bus.argc_q !== 2'd0 || bus.is_alu_q !== 1'b1)
      $display("FAIL reg_hold got %b/%0d/%b want 0010/0/1", bus.aluop_q, bus.argc_q, bus.is_alu_q);
    else pass_cnt++;
    @(negedge clk);
    bus.dec_en = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.aluop_q !== 4'b0000 || bus.argc_q !== 2'd2 || bus.is_alu_q !== 1'b0)
      $display("FAIL reg_recapture got %b/%0d/%b want 0000/2/0", bus.aluop_q, bus.argc_q, bus.is_alu_q);
    else pass_cnt++;
    @(negedge clk);
    bus.dec_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [3] = '{8'h64, 8'hC8, 8'h82};
    logic [3:0] wa  [3] = '{4'b0001, 4'b0000, 4'b1001};
    logic [1:0] wc  [3] = '{2'd0, 2'd3, 2'd0};
    @(negedge clk);
    bus.dec_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.opcode = ops[j];
      @(posedge clk); #1;
      total_cnt++;
      if (bus.aluop_q !== wa[j] || bus.argc_q !== wc[j])
        $display("FAIL back_to_back op=%h got %b/%0d want %b/%0d",
                 ops[j], bus.aluop_q, bus.argc_q, wa[j], wc[j]);
      else pass_cnt++;
      @(negedge clk);
    end
    bus.dec_en = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.opcode = 8'h7E;
    bus.dec_en = 1'b1;
    @(posedge clk); #1;
    bus.dec_en = 1'b0;
    total_cnt++;
    if (bus.aluop_q !== 4'hF) $display("FAIL async_pre_capture got %h want %h", bus.aluop_q, 4'hF);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.aluop_q !== 4'h0 || bus.is_alu_q !== 1'b0 || bus.argc_q !== 2'd0)
      $display("FAIL async_reset_q got %h/%0d/%b want 0/0/0", bus.aluop_q, bus.argc_q, bus.is_alu_q);
    else pass_cnt++;
    total_cnt++;
    if (bus.aluop !== 4'hF) $display("FAIL async_reset_comb got %h want %h", bus.aluop, 4'hF);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive();
    logic [3:0] ea;
    logic [1:0] ec;
    logic       ei;
    for (int k = 0; k < 256; k++) begin
      bus.opcode = 8'(k);
      #1;
      ref_model(8'(k), ea, ec, ei);
      total_cnt++;
      if ($isunknown({bus.aluop, bus.argc, bus.is_alu}))
        $display("FAIL sweep_xz op=%h got %b/%b/%b", 8'(k), bus.aluop, bus.argc, bus.is_alu);
      else pass_cnt++;
      total_cnt++;
      if (bus.aluop !== ea) $display("FAIL sweep_aluop op=%h got %b want %b", 8'(k), bus.aluop, ea);
      else pass_cnt++;
      total_cnt++;
      if (bus.argc !== ec) $display("FAIL sweep_argc op=%h got %0d want %0d", 8'(k), bus.argc, ec);
      else pass_cnt++;
      total_cnt++;
      if (bus.is_alu !== ei) $display("FAIL sweep_is_alu op=%h got %b want %b", 8'(k), bus.is_alu, ei);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst_n      = 1'b0;
    bus.opcode = 8'h00;
    bus.dec_en = 1'b0;
    test_reset();
    test_alu_sweep();
    test_unlisted();
    test_argc();
    test_registered();
    test_back_to_back();
    test_async_reset();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
